// File: rtl/pipe_hazard_ctrl_if.sv
// Signal bundle between the Y86-64 pipeline datapath and its hazard/control unit.
// The master drives the stage state; the slave (the control unit) returns stall/bubble controls.
interface pipe_hazard_ctrl_if #(
  parameter int ICODE_W = 4,
  parameter int REG_W   = 4,
  parameter int STAT_W  = 4,
  parameter int NUM_SRC = 2,
  parameter int CNT_W   = 16
);
  logic [ICODE_W-1:0]       D_icode;
  logic [ICODE_W-1:0]       E_icode;
  logic [ICODE_W-1:0]       M_icode;
  logic [NUM_SRC*REG_W-1:0] d_src;
  logic [REG_W-1:0]         E_dstM;
  logic                     e_Cnd;
  logic [STAT_W-1:0]        m_stat;
  logic [STAT_W-1:0]        W_stat;
  logic                     cnt_clr;
  logic                     F_stall;
  logic                     D_stall;
  logic                     D_bubble;
  logic                     E_bubble;
  logic                     M_bubble;
  logic                     W_stall;
  logic                     ret_busy;
  logic                     halted;
  logic [STAT_W-1:0]        exc_code;
  logic [CNT_W-1:0]         load_use_cnt;
  logic [CNT_W-1:0]         ret_cnt;
  logic [CNT_W-1:0]         mispred_cnt;

  modport master (
    output D_icode, E_icode, M_icode, d_src, E_dstM, e_Cnd, m_stat, W_stat, cnt_clr,
    input  F_stall, D_stall, D_bubble, E_bubble, M_bubble, W_stall, ret_busy,
    input  halted, exc_code, load_use_cnt, ret_cnt, mispred_cnt
  );

  modport slave (
    input  D_icode, E_icode, M_icode, d_src, E_dstM, e_Cnd, m_stat, W_stat, cnt_clr,
    output F_stall, D_stall, D_bubble, E_bubble, M_bubble, W_stall, ret_busy,
    output halted, exc_code, load_use_cnt, ret_cnt, mispred_cnt
  );
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// Y86-64 pipeline hazard/control unit: combinational stall/bubble controls, a sticky
// HALTED state with latched exception code, and saturating per-event counters.
module pipe_hazard_ctrl #(
  parameter int ICODE_W = 4,
  parameter int REG_W   = 4,
  parameter int STAT_W  = 4,
  parameter int NUM_SRC = 2,
  parameter int CNT_W   = 16
) (
  input logic               clk,
  input logic               rst_n,
  pipe_hazard_ctrl_if.slave hz
);

  localparam logic [REG_W-1:0]   RNONE   = '1;
  localparam logic [ICODE_W-1:0] I_MRMOV = ICODE_W'(5);
  localparam logic [ICODE_W-1:0] I_JXX   = ICODE_W'(7);
  localparam logic [ICODE_W-1:0] I_RET   = ICODE_W'(9);
  localparam logic [ICODE_W-1:0] I_POPQ  = ICODE_W'(11);

  typedef enum logic [0:0] {
    ST_RUN    = 1'b0,
    ST_HALTED = 1'b1
  } state_t;

  // Any status other than AOK (bit 0) is an exception.
  function automatic logic exc_f(input logic [STAT_W-1:0] s);
    return |s[STAT_W-1:1];
  endfunction

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c, input logic en);
    if (en && (c != {CNT_W{1'b1}})) begin
      return c + CNT_W'(1);
    end else begin
      return c;
    end
  endfunction

  state_t            state_q, state_d;
  logic [STAT_W-1:0] exc_code_q, exc_code_d;
  logic [CNT_W-1:0]  lu_cnt_q, lu_cnt_d;
  logic [CNT_W-1:0]  ret_cnt_q, ret_cnt_d;
  logic [CNT_W-1:0]  mp_cnt_q, mp_cnt_d;

  logic src_hit_s;
  logic load_use_s;
  logic ret_busy_s;
  logic mispredict_s;
  logic f_stall_s, d_stall_s, d_bubble_s, e_bubble_s, m_bubble_s, w_stall_s;

  always_comb begin
    src_hit_s = 1'b0;
    for (int i = 0; i < NUM_SRC; i++) begin
      src_hit_s = src_hit_s | (hz.d_src[i*REG_W +: REG_W] == hz.E_dstM);
    end
    // RNONE destination never matches, so RNONE source slots cannot cause a stall.
    load_use_s   = ((hz.E_icode == I_MRMOV) || (hz.E_icode == I_POPQ)) &&
                   (hz.E_dstM != RNONE) && src_hit_s;
    ret_busy_s   = (hz.D_icode == I_RET) || (hz.E_icode == I_RET) || (hz.M_icode == I_RET);
    mispredict_s = (hz.E_icode == I_JXX) && !hz.e_Cnd;
  end

  always_comb begin
    state_d    = state_q;
    exc_code_d = exc_code_q;
    f_stall_s  = 1'b0;
    d_stall_s  = 1'b0;
    d_bubble_s = 1'b0;
    e_bubble_s = 1'b0;
    m_bubble_s = 1'b0;
    w_stall_s  = 1'b0;
    case (state_q)
      ST_RUN: begin
        f_stall_s  = load_use_s || ret_busy_s;
        d_stall_s  = load_use_s;
        d_bubble_s = mispredict_s || (!load_use_s && ret_busy_s);
        e_bubble_s = mispredict_s || load_use_s;
        m_bubble_s = exc_f(hz.m_stat) || exc_f(hz.W_stat);
        w_stall_s  = exc_f(hz.W_stat);
        if (exc_f(hz.W_stat)) begin
          state_d    = ST_HALTED;
          exc_code_d = hz.W_stat;
        end else begin
          state_d    = ST_RUN;
        end
      end
      ST_HALTED: begin
        f_stall_s  = 1'b1;
        d_stall_s  = 1'b1;
        m_bubble_s = 1'b1;
        w_stall_s  = 1'b1;
      end
      default: begin
        state_d = ST_RUN;
      end
    endcase
    if (!rst_n) begin
      f_stall_s  = 1'b0;
      d_stall_s  = 1'b0;
      d_bubble_s = 1'b0;
      e_bubble_s = 1'b0;
      m_bubble_s = 1'b0;
      w_stall_s  = 1'b0;
    end else begin
      state_d = state_d;
    end
  end

  always_comb begin
    lu_cnt_d  = lu_cnt_q;
    ret_cnt_d = ret_cnt_q;
    mp_cnt_d  = mp_cnt_q;
    if (hz.cnt_clr) begin
      lu_cnt_d  = '0;
      ret_cnt_d = '0;
      mp_cnt_d  = '0;
    end else if (state_q == ST_RUN) begin
      lu_cnt_d  = sat_inc(lu_cnt_q, load_use_s);
      ret_cnt_d = sat_inc(ret_cnt_q, ret_busy_s);
      mp_cnt_d  = sat_inc(mp_cnt_q, mispredict_s);
    end else begin
      lu_cnt_d  = lu_cnt_q;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= ST_RUN;
      exc_code_q <= '0;
      lu_cnt_q   <= '0;
      ret_cnt_q  <= '0;
      mp_cnt_q   <= '0;
    end else begin
      state_q    <= state_d;
      exc_code_q <= exc_code_d;
      lu_cnt_q   <= lu_cnt_d;
      ret_cnt_q  <= ret_cnt_d;
      mp_cnt_q   <= mp_cnt_d;
    end
  end

  assign hz.F_stall      = f_stall_s;
  assign hz.D_stall      = d_stall_s;
  assign hz.D_bubble     = d_bubble_s;
  assign hz.E_bubble     = e_bubble_s;
  assign hz.M_bubble     = m_bubble_s;
  assign hz.W_stall      = w_stall_s;
  assign hz.ret_busy     = ret_busy_s;
  assign hz.halted       = (state_q == ST_HALTED);
  assign hz.exc_code     = exc_code_q;
  assign hz.load_use_cnt = lu_cnt_q;
  assign hz.ret_cnt      = ret_cnt_q;
  assign hz.mispred_cnt  = mp_cnt_q;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Self-checking bench for pipe_hazard_ctrl: a vector table plus hand-written halt,
// reset and saturation sequences, with expected controls queued at drive time.
module tb_pipe_hazard_ctrl;
  localparam int ICODE_W = 4;
  localparam int REG_W   = 4;
  localparam int STAT_W  = 4;
  localparam int NUM_SRC = 3;
  localparam int CNT_W   = 4;

  localparam logic [3:0] AOK = 4'b0001;
  localparam logic [3:0] HLT = 4'b0010;
  localparam logic [3:0] ADR = 4'b0100;
  localparam logic [3:0] INS = 4'b1000;

  // ctl bit order: {F_stall, D_stall, D_bubble, E_bubble, M_bubble, W_stall}
  typedef struct packed {
    logic [3:0]  d_i;
    logic [3:0]  e_i;
    logic [3:0]  m_i;
    logic [11:0] src;
    logic [3:0]  dstm;
    logic        cnd;
    logic [3:0]  ms;
    logic [3:0]  ws;
    logic [5:0]  ctl;
    logic        rb;
    logic        lu;
    logic        rt;
    logic        mp;
  } vec_t;

  typedef struct packed {
    logic [5:0] ctl;
    logic       rb;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;
  logic clr;
  int   checks = 0;
  int   errors = 0;
  int   m_lu, m_rt, m_mp;
  logic m_halt;
  logic [3:0] m_exc;
  exp_t sb_q[$];
  vec_t tbl[17];

  always #5 clk = ~clk;

  pipe_hazard_ctrl_if #(.ICODE_W(ICODE_W), .REG_W(REG_W), .STAT_W(STAT_W),
                        .NUM_SRC(NUM_SRC), .CNT_W(CNT_W)) hz ();

  pipe_hazard_ctrl #(.ICODE_W(ICODE_W), .REG_W(REG_W), .STAT_W(STAT_W),
                     .NUM_SRC(NUM_SRC), .CNT_W(CNT_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .hz    (hz)
  );

  function automatic vec_t mk(input logic [3:0] d, input logic [3:0] e, input logic [3:0] m,
                              input logic [11:0] src, input logic [3:0] dstm, input logic cnd,
                              input logic [3:0] ms, input logic [3:0] ws, input logic [5:0] ctl,
                              input logic rb, input logic lu, input logic rt, input logic mp);
    vec_t v;
    v.d_i = d; v.e_i = e; v.m_i = m; v.src = src; v.dstm = dstm; v.cnd = cnd;
    v.ms = ms; v.ws = ws; v.ctl = ctl; v.rb = rb; v.lu = lu; v.rt = rt; v.mp = mp;
    return v;
  endfunction

  function automatic int sat(input int x);
    return (x < 15) ? x + 1 : 15;
  endfunction

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    hz.D_icode = v.d_i;
    hz.E_icode = v.e_i;
    hz.M_icode = v.m_i;
    hz.d_src   = v.src;
    hz.E_dstM  = v.dstm;
    hz.e_Cnd   = v.cnd;
    hz.m_stat  = v.ms;
    hz.W_stat  = v.ws;
    hz.cnt_clr = clr;
  endtask

  // Drive one cycle, check combinational controls mid-cycle, then state after the edge.
  task automatic apply(input vec_t v, input string nm);
    exp_t e;
    exp_t got;
    drive(v);
    sb_q.push_back({v.ctl, v.rb});
    @(negedge clk);
    if (sb_q.size() == 0) begin
      check({nm, ".sb_empty"}, 32'd1, 32'd0);
    end else begin
      e = sb_q.pop_front();
      got.ctl = {hz.F_stall, hz.D_stall, hz.D_bubble, hz.E_bubble, hz.M_bubble, hz.W_stall};
      got.rb  = hz.ret_busy;
      check({nm, ".ctl"}, 32'(got.ctl), 32'(e.ctl));
      check({nm, ".ret_busy"}, 32'(got.rb), 32'(e.rb));
    end
    @(posedge clk);
    if (!rst_n) begin
      m_lu = 0; m_rt = 0; m_mp = 0; m_halt = 1'b0; m_exc = 4'h0;
    end else begin
      if (clr) begin
        m_lu = 0; m_rt = 0; m_mp = 0;
      end else if (!m_halt) begin
        if (v.lu) m_lu = sat(m_lu);
        if (v.rt) m_rt = sat(m_rt);
        if (v.mp) m_mp = sat(m_mp);
      end
      if (!m_halt && (|v.ws[3:1])) begin
        m_halt = 1'b1;
        m_exc  = v.ws;
      end
    end
    #1;
    check({nm, ".halted"}, 32'(hz.halted), 32'(m_halt));
    check({nm, ".exc_code"}, 32'(hz.exc_code), 32'(m_exc));
    check({nm, ".load_use_cnt"}, 32'(hz.load_use_cnt), 32'(m_lu));
    check({nm, ".ret_cnt"}, 32'(hz.ret_cnt), 32'(m_rt));
    check({nm, ".mispred_cnt"}, 32'(hz.mispred_cnt), 32'(m_mp));
  endtask

  initial begin
    vec_t idle, luv, mpv;
    idle = mk(4'h1, 4'h1, 4'h1, 12'h000, 4'hF, 1'b1, AOK, AOK, 6'b000000, 1'b0, 1'b0, 1'b0, 1'b0);
    luv  = mk(4'h1, 4'h5, 4'h1, 12'h030, 4'h3, 1'b1, AOK, AOK, 6'b110100, 1'b0, 1'b1, 1'b0, 1'b0);
    mpv  = mk(4'h1, 4'h7, 4'h1, 12'h000, 4'hF, 1'b0, AOK, AOK, 6'b001100, 1'b0, 1'b0, 1'b0, 1'b1);

    tbl[0]  = idle;
    tbl[1]  = luv;
    tbl[2]  = mk(4'h1, 4'h5, 4'h1, 12'h300, 4'h3, 1'b1, AOK, AOK, 6'b110100, 1'b0, 1'b1, 1'b0, 1'b0);
    tbl[3]  = mk(4'h1, 4'hB, 4'h1, 12'h002, 4'h2, 1'b1, AOK, AOK, 6'b110100, 1'b0, 1'b1, 1'b0, 1'b0);
    tbl[4]  = mk(4'h1, 4'hB, 4'h1, 12'hFFF, 4'hF, 1'b1, AOK, AOK, 6'b000000, 1'b0, 1'b0, 1'b0, 1'b0);
    tbl[5]  = mk(4'h1, 4'h5, 4'h1, 12'h444, 4'h3, 1'b1, AOK, AOK, 6'b000000, 1'b0, 1'b0, 1'b0, 1'b0);
    tbl[6]  = mk(4'h1, 4'h6, 4'h1, 12'h030, 4'h3, 1'b1, AOK, AOK, 6'b000000, 1'b0, 1'b0, 1'b0, 1'b0);
    tbl[7]  = mk(4'h9, 4'h1, 4'h1, 12'h000, 4'hF, 1'b1, AOK, AOK, 6'b101000, 1'b1, 1'b0, 1'b1, 1'b0);
    tbl[8]  = mk(4'h1, 4'h9, 4'h1, 12'h000, 4'hF, 1'b1, AOK, AOK, 6'b101000, 1'b1, 1'b0, 1'b1, 1'b0);
    tbl[9]  = mk(4'h1, 4'h1, 4'h9, 12'h000, 4'hF, 1'b1, AOK, AOK, 6'b101000, 1'b1, 1'b0, 1'b1, 1'b0);
    tbl[10] = mk(4'h9, 4'h5, 4'h1, 12'h030, 4'h3, 1'b1, AOK, AOK, 6'b110100, 1'b1, 1'b1, 1'b1, 1'b0);
    tbl[11] = mpv;
    tbl[12] = mk(4'h1, 4'h7, 4'h1, 12'h000, 4'hF, 1'b1, AOK, AOK, 6'b000000, 1'b0, 1'b0, 1'b0, 1'b0);
    tbl[13] = mk(4'h9, 4'h7, 4'h1, 12'h000, 4'hF, 1'b0, AOK, AOK, 6'b101100, 1'b1, 1'b0, 1'b1, 1'b1);
    tbl[14] = mk(4'h1, 4'h1, 4'h1, 12'h000, 4'hF, 1'b1, ADR, AOK, 6'b000010, 1'b0, 1'b0, 1'b0, 1'b0);
    tbl[15] = mk(4'h1, 4'h1, 4'h1, 12'h000, 4'hF, 1'b1, INS, AOK, 6'b000010, 1'b0, 1'b0, 1'b0, 1'b0);
    tbl[16] = mk(4'h1, 4'h1, 4'h1, 12'h000, 4'hF, 1'b1, HLT, AOK, 6'b000010, 1'b0, 1'b0, 1'b0, 1'b0);

    m_lu = 0; m_rt = 0; m_mp = 0; m_halt = 1'b0; m_exc = 4'h0;
    clr   = 1'b0;
    rst_n = 1'b0;

    // Reset with a load-use present: controls forced low, state cleared.
    apply(mk(4'h9, 4'h5, 4'h1, 12'h030, 4'h3, 1'b1, AOK, AOK, 6'b000000, 1'b1, 1'b1, 1'b1, 1'b0),
          "reset0");
    apply(mk(4'h9, 4'h5, 4'h1, 12'h030, 4'h3, 1'b1, AOK, AOK, 6'b000000, 1'b1, 1'b1, 1'b1, 1'b0),
          "reset1");
    rst_n = 1'b1;

    for (int i = 0; i < 17; i++) begin
      apply(tbl[i], $sformatf("vec%0d", i));
    end

    // Exception walks from M into W, then the unit halts and freezes counters.
    apply(mk(4'h1, 4'h1, 4'h1, 12'h000, 4'hF, 1'b1, ADR, AOK, 6'b000010, 1'b0, 1'b0, 1'b0, 1'b0), "exc_m");
    apply(mk(4'h1, 4'h1, 4'h1, 12'h000, 4'hF, 1'b1, AOK, ADR, 6'b000011, 1'b0, 1'b0, 1'b0, 1'b0), "exc_w");
    check("halt_entered", 32'(hz.halted), 32'd1);
    apply(mk(4'h9, 4'h5, 4'h1, 12'h030, 4'h3, 1'b1, AOK, AOK, 6'b110011, 1'b1, 1'b1, 1'b1, 1'b0), "halt_lu");
    apply(mk(4'h1, 4'h7, 4'h1, 12'h000, 4'hF, 1'b0, AOK, AOK, 6'b110011, 1'b0, 1'b0, 1'b0, 1'b1), "halt_mp");
    apply(mk(4'h1, 4'h1, 4'h1, 12'h000, 4'hF, 1'b1, AOK, INS, 6'b110011, 1'b0, 1'b0, 1'b0, 1'b0), "halt_ins");
    check("exc_code_sticky", 32'(hz.exc_code), 32'(ADR));

    rst_n = 1'b0;
    apply(mk(4'h1, 4'h5, 4'h1, 12'h030, 4'h3, 1'b1, AOK, AOK, 6'b000000, 1'b0, 1'b1, 1'b0, 1'b0), "halt_rst");
    rst_n = 1'b1;
    apply(idle, "post_rst");

    // Saturation at 15 with a 4-bit counter, then clear beats increment.
    for (int i = 0; i < 20; i++) begin
      apply(mpv, $sformatf("sat%0d", i));
    end
    check("mispred_saturated", 32'(hz.mispred_cnt), 32'd15);
    clr = 1'b1;
    apply(mpv, "clr_mp");
    check("mispred_cleared", 32'(hz.mispred_cnt), 32'd0);
    clr = 1'b0;
    apply(mpv, "after_clr");
    check("mispred_one", 32'(hz.mispred_cnt), 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
- Parametrised pipeline hazard and control unit for the Y86-64 five-stage pipeline; successor to the fixed two-source combinational control logic.
- Produces the per-cycle stall and bubble controls for the F/D/E/M/W pipeline registers, covering load-use, ret, mispredicted-jump and exception cases.
- Adds a sticky HALTED state with a latched exception code, a ret-in-flight indicator, and saturating per-event performance counters.

Parameters:
ICODE_W, 4, instruction code width
REG_W, 4, register ID width; all-ones value is RNONE (4'hF at default)
STAT_W, 4, one-hot status width: AOK=0001, HLT=0010, ADR=0100, INS=1000
NUM_SRC, 2, number of decode-stage source register IDs checked for load-use
CNT_W, 16, performance counter width

Ports:
clk  in  1  clock, all state updates on rising edge
rst_n  in  1  synchronous active-low reset
D_icode  in  ICODE_W  icode in Decode
E_icode  in  ICODE_W  icode in Execute
M_icode  in  ICODE_W  icode in Memory
d_src  in  NUM_SRC*REG_W  decode source IDs, slot i at [i*REG_W +: REG_W]
E_dstM  in  REG_W  memory destination of the Execute instruction
e_Cnd  in  1  Execute-stage condition result
m_stat  in  STAT_W  Memory-stage status
W_stat  in  STAT_W  Writeback-stage status
cnt_clr  in  1  synchronous clear of all performance counters
F_stall  out  1  hold the F register
D_stall  out  1  hold the D register
D_bubble  out  1  inject a nop into D
E_bubble  out  1  inject a nop into E
M_bubble  out  1  inject a nop into M
W_stall  out  1  hold the W register
ret_busy  out  1  a ret is in D, E or M
halted  out  1  FSM is in HALTED
exc_code  out  STAT_W  first exceptional W_stat, latched
load_use_cnt  out  CNT_W  cycles with load_use asserted
ret_cnt  out  CNT_W  cycles with ret_busy asserted
mispred_cnt  out  CNT_W  cycles with mispredict asserted

Behaviour:
- Status decode: exc(s) = |s[STAT_W-1:1].
- Hazard terms (combinational, same cycle):
  - load_use = (E_icode==5 || E_icode==B) && E_dstM!=RNONE && (some i: d_src[i]==E_dstM).
  - ret_busy = D_icode==9 || E_icode==9 || M_icode==9.
  - mispredict = E_icode==7 && !e_Cnd.
- FSM states: RUN, HALTED.
  - RUN -> HALTED on a clock edge when exc(W_stat) is true; exc_code <= W_stat on that edge.
  - HALTED exits only via reset.
  - exc_code holds its value until reset.
- Outputs in RUN (combinational):
  - F_stall = load_use || ret_busy
  - D_stall = load_use
  - D_bubble = mispredict || (!load_use && ret_busy)
  - E_bubble = mispredict || load_use
  - M_bubble = exc(m_stat) || exc(W_stat)
  - W_stall = exc(W_stat)
- Outputs in HALTED: F_stall = D_stall = M_bubble = W_stall = 1; D_bubble = E_bubble = 0.
- Rule: D_stall and D_bubble are never both 1.
- Counters:
  - Each counter increments by 1 per cycle in RUN while its event term is 1.
  - Counters saturate at all-ones and do not wrap.
  - Counters freeze in HALTED.
  - cnt_clr zeroes all counters and takes priority over increment; it is ignored while rst_n is low because reset already clears.
- Reset (rst_n sampled low at an edge): state=RUN, exc_code=0, all counters=0.
  - While rst_n is low, all stall and bubble outputs are forced to 0.
  - halted=0 from the first reset edge.
  - Reset asserted mid-halt returns to RUN on that edge.
- Latency: stall and bubble outputs have 0 cycles of latency from their inputs. halted and exc_code update 1 cycle after exc(W_stat). Counters reflect an event 1 cycle after it.
- Slot check: a d_src slot equal to RNONE never matches, because of the E_dstM!=RNONE guard.
- Simultaneous events:
  - load_use with ret_busy: F_stall=1, D_stall=1, D_bubble=0, E_bubble=1.
  - mispredict with ret in D: D_bubble=1, E_bubble=1, F_stall=1.
  - Both load_use_cnt and ret_cnt increment in such cycles.

Test Plan:
- Load-use: E_icode=5, E_dstM=3, d_src slot1=3, others 0 -> F_stall=1, D_stall=1, E_bubble=1, D_bubble=0. load_use_cnt goes 0 to 1 on the next edge. Repeat with NUM_SRC=3 and the match on slot2 only -> same response.
- RNONE guard: E_icode=B, E_dstM=F, d_src={F,F} -> all outputs 0, counters unchanged.
- Ret drain: D_icode=9 for one cycle, then E_icode=9, then M_icode=9 -> F_stall=1 and D_bubble=1 for 3 cycles, ret_busy=1 for 3 cycles, ret_cnt=3. Combine with load-use in the first cycle -> D_stall=1, D_bubble=0.
- Mispredict: E_icode=7, e_Cnd=0 -> D_bubble=1, E_bubble=1, F_stall=0. Same with e_Cnd=1 -> all 0.
- Exception and halt:
  - m_stat=0100 -> M_bubble=1, W_stall=0.
  - Next cycle W_stat=0100 -> W_stall=1, M_bubble=1.
  - On the following edge: halted=1, exc_code=0100; F_stall=D_stall=1; counters frozen while hazards are driven.
  - W_stat=1000 later -> exc_code stays 0100.
  - rst_n=0 for one edge -> halted=0, exc_code=0, counters=0.
- Saturation and clear: CNT_W=4, hold mispredict 20 cycles -> mispred_cnt=15. cnt_clr with mispredict=1 -> mispred_cnt=0 on that edge, then 1 on the next.
